// File: rtl/ifetch_unit_pkg.sv
// ============================================================================
// Module      : ifetch_unit_pkg
// Description : Shared types and constants for the instruction-fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_unit_pkg;

  localparam logic        c_PC_REG_NPC  = 1'b1;
  localparam logic        c_PC_REG_HOLD = 1'b0;
  localparam logic [31:0] c_INSTR_NOP   = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'b00,
    IF_REQ   = 2'b01,
    IF_DRAIN = 2'b10,
    IF_HALT  = 2'b11
  } if_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_entry_t;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_unit_if.sv
// ============================================================================
// Module      : ifetch_unit_if
// Description : PC-register, instruction-memory and IF/ID signals of the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifetch_unit_if;
  logic [31:0] pc;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_exc;
  logic        id_ready;
  logic        flush;

  modport master (
    input  pc, imem_ack, imem_rdata, id_ready, flush,
    output pc_write, imem_req, imem_addr, if_valid, if_instr, if_pc, if_exc
  );

  modport slave (
    output pc, imem_ack, imem_rdata, id_ready, flush,
    input  pc_write, imem_req, imem_addr, if_valid, if_instr, if_pc, if_exc
  );
endinterface

`default_nettype wire

// File: rtl/ifetch_unit_fifo.sv
// ============================================================================
// Module      : ifetch_unit_fifo
// Description : DEPTH-entry {pc, instr, exc} FIFO with push, pop and clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  wire logic         clock,
  input  wire logic         reset,
  input  wire logic         i_push,
  input  wire fetch_entry_t i_push_data,
  input  wire logic         i_pop,
  input  wire logic         i_clear,
  output fetch_entry_t      o_head,
  output logic              o_head_valid,
  output logic [PTR_W:0]    o_count
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_pop_ok;

  // Popping an empty FIFO is a no-op.
  assign w_pop_ok = i_pop & (r_count != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head       = r_mem[r_rd_ptr];
  assign o_head_valid = (r_count != '0);
  assign o_count      = r_count;

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch: PC sampling, imem req/ack, IF/ID buffering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  wire logic    clock,
  input  wire logic    reset,
  ifetch_unit_if.master bus
);

  localparam logic [PTR_W:0] c_DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  if_state_t      r_state;
  if_state_t      w_state_next;
  logic [31:0]    r_imem_addr;
  logic           w_addr_load;
  logic           w_push;
  logic           w_pop;
  logic           w_room;
  logic           w_head_valid;
  fetch_entry_t   w_push_data;
  fetch_entry_t   w_head;
  logic [PTR_W:0] w_count;

  // Only one fetch is ever outstanding, so checking room at issue keeps push off a full FIFO.
  assign w_room = (w_count < c_DEPTH_CNT);
  assign w_pop  = w_head_valid & bus.id_ready & ~bus.flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IF_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_imem_addr <= '0;
    end else if (w_addr_load) begin
      r_imem_addr <= word_addr(bus.pc);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_load  = 1'b0;
    w_push       = 1'b0;
    w_push_data  = '0;
    case (r_state)
      IF_IDLE: begin
        if (!bus.flush && w_room) begin
          if (is_misaligned(bus.pc)) begin
            w_push       = 1'b1;
            w_push_data  = '{pc: bus.pc, instr: c_INSTR_NOP, exc: 1'b1};
            w_state_next = IF_HALT;
          end else begin
            w_addr_load  = 1'b1;
            w_state_next = IF_REQ;
          end
        end
      end
      IF_REQ: begin
        if (bus.imem_ack) begin
          if (!bus.flush) begin
            w_push      = 1'b1;
            w_push_data = '{pc: r_imem_addr, instr: bus.imem_rdata, exc: 1'b0};
          end
          w_state_next = IF_IDLE;
        end else if (bus.flush) begin
          // Memory cannot abort: keep requesting and throw the data away.
          w_state_next = IF_DRAIN;
        end
      end
      IF_DRAIN: begin
        if (bus.imem_ack) begin
          w_state_next = IF_IDLE;
        end
      end
      IF_HALT: begin
        if (bus.flush) begin
          w_state_next = IF_IDLE;
        end
      end
      default: w_state_next = IF_IDLE;
    endcase
  end

  ifetch_unit_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_data  (w_push_data),
    .i_pop        (w_pop),
    .i_clear      (bus.flush),
    .o_head       (w_head),
    .o_head_valid (w_head_valid),
    .o_count      (w_count)
  );

  assign bus.imem_req  = (r_state == IF_REQ) || (r_state == IF_DRAIN);
  assign bus.imem_addr = r_imem_addr;
  assign bus.pc_write  = ((r_state == IF_REQ) && bus.imem_ack && !bus.flush)
                         ? c_PC_REG_NPC : c_PC_REG_HOLD;
  assign bus.if_valid  = w_head_valid;
  assign bus.if_instr  = w_head.instr;
  assign bus.if_pc     = w_head.pc;
  assign bus.if_exc    = w_head.exc;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Directed cycle-by-cycle vectors for ifetch_unit plus async reset check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        idr;
    logic        flush;
    logic        req;
    logic [31:0] addr;
    logic        pcw;
    logic        valid;
    logic [31:0] hpc;
    logic [31:0] hinstr;
    logic        hexc;
  } vec_t;

  localparam int c_NVEC = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs [c_NVEC];

  ifetch_unit_if bus ();

  ifetch_unit #(.DEPTH(2), .PTR_W(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [31:0] pc, input logic ack, input logic [31:0] rdata,
                              input logic idr, input logic flush, input logic req,
                              input logic [31:0] addr, input logic pcw, input logic valid,
                              input logic [31:0] hpc, input logic [31:0] hinstr, input logic hexc);
    vec_t v;
    v.pc = pc; v.ack = ack; v.rdata = rdata; v.idr = idr; v.flush = flush;
    v.req = req; v.addr = addr; v.pcw = pcw; v.valid = valid;
    v.hpc = hpc; v.hinstr = hinstr; v.hexc = hexc;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  initial begin
    //           pc            ack rdata         idr fl  req addr          pcw val hpc           hinstr        exc
    vecs[0]  = mk(32'h0000_3000, 0, 32'h0,        1, 0,  0, 32'h0,         0, 0, 32'h0,         32'h0,         0);
    vecs[1]  = mk(32'h0000_3000, 1, 32'h1111_0001, 1, 0, 1, 32'h0000_3000, 1, 0, 32'h0,         32'h0,         0);
    vecs[2]  = mk(32'h0000_3004, 0, 32'h0,        0, 0,  0, 32'h0000_3000, 0, 1, 32'h0000_3000, 32'h1111_0001, 0);
    vecs[3]  = mk(32'h0000_3004, 1, 32'h2222_0002, 0, 0, 1, 32'h0000_3004, 1, 1, 32'h0000_3000, 32'h1111_0001, 0);
    vecs[4]  = mk(32'h0000_3008, 0, 32'h0,        0, 0,  0, 32'h0000_3004, 0, 1, 32'h0000_3000, 32'h1111_0001, 0);
    vecs[5]  = mk(32'h0000_3008, 1, 32'h0,        0, 0,  0, 32'h0000_3004, 0, 1, 32'h0000_3000, 32'h1111_0001, 0);
    vecs[6]  = mk(32'h0000_3008, 0, 32'h0,        1, 0,  0, 32'h0000_3004, 0, 1, 32'h0000_3000, 32'h1111_0001, 0);
    vecs[7]  = mk(32'h0000_3008, 0, 32'h0,        1, 0,  0, 32'h0000_3004, 0, 1, 32'h0000_3004, 32'h2222_0002, 0);
    vecs[8]  = mk(32'h0000_3008, 0, 32'h0,        1, 0,  1, 32'h0000_3008, 0, 0, 32'h0,         32'h0,         0);
    vecs[9]  = mk(32'h0000_3008, 0, 32'h0,        1, 0,  1, 32'h0000_3008, 0, 0, 32'h0,         32'h0,         0);
    vecs[10] = mk(32'h0000_3008, 0, 32'h0,        1, 0,  1, 32'h0000_3008, 0, 0, 32'h0,         32'h0,         0);
    vecs[11] = mk(32'h0000_3008, 1, 32'h3333_0003, 1, 0, 1, 32'h0000_3008, 1, 0, 32'h0,         32'h0,         0);
    vecs[12] = mk(32'h0000_300C, 0, 32'h0,        1, 0,  0, 32'h0000_3008, 0, 1, 32'h0000_3008, 32'h3333_0003, 0);
    vecs[13] = mk(32'h0000_300C, 0, 32'h0,        1, 1,  1, 32'h0000_300C, 0, 0, 32'h0,         32'h0,         0);
    vecs[14] = mk(32'h0000_4000, 0, 32'h0,        1, 0,  1, 32'h0000_300C, 0, 0, 32'h0,         32'h0,         0);
    vecs[15] = mk(32'h0000_4000, 1, 32'hDEAD_BEEF, 1, 0, 1, 32'h0000_300C, 0, 0, 32'h0,         32'h0,         0);
    vecs[16] = mk(32'h0000_4000, 0, 32'h0,        1, 0,  0, 32'h0000_300C, 0, 0, 32'h0,         32'h0,         0);
    vecs[17] = mk(32'h0000_4000, 1, 32'h4444_0004, 1, 1, 1, 32'h0000_4000, 0, 0, 32'h0,         32'h0,         0);
    vecs[18] = mk(32'h0000_5000, 0, 32'h0,        1, 0,  0, 32'h0000_4000, 0, 0, 32'h0,         32'h0,         0);
    vecs[19] = mk(32'h0000_5000, 1, 32'h5555_0005, 0, 0, 1, 32'h0000_5000, 1, 0, 32'h0,         32'h0,         0);
    vecs[20] = mk(32'h0000_5004, 0, 32'h0,        1, 1,  0, 32'h0000_5000, 0, 1, 32'h0000_5000, 32'h5555_0005, 0);
    vecs[21] = mk(32'h0000_5004, 0, 32'h0,        1, 0,  0, 32'h0000_5000, 0, 0, 32'h0,         32'h0,         0);
    vecs[22] = mk(32'h0000_5004, 1, 32'h6666_0006, 1, 0, 1, 32'h0000_5004, 1, 0, 32'h0,         32'h0,         0);
    vecs[23] = mk(32'h0000_3002, 0, 32'h0,        0, 0,  0, 32'h0000_5004, 0, 1, 32'h0000_5004, 32'h6666_0006, 0);
    vecs[24] = mk(32'h0000_3002, 0, 32'h0,        1, 0,  0, 32'h0000_5004, 0, 1, 32'h0000_5004, 32'h6666_0006, 0);
    vecs[25] = mk(32'h0000_3002, 0, 32'h0,        0, 0,  0, 32'h0000_5004, 0, 1, 32'h0000_3002, 32'h0,         1);
    vecs[26] = mk(32'h0000_6000, 0, 32'h0,        0, 0,  0, 32'h0000_5004, 0, 1, 32'h0000_3002, 32'h0,         1);
    vecs[27] = mk(32'h0000_6000, 0, 32'h0,        0, 1,  0, 32'h0000_5004, 0, 1, 32'h0000_3002, 32'h0,         1);
    vecs[28] = mk(32'h0000_6000, 0, 32'h0,        0, 0,  0, 32'h0000_5004, 0, 0, 32'h0,         32'h0,         0);
    vecs[29] = mk(32'h0000_6000, 0, 32'h0,        0, 0,  1, 32'h0000_6000, 0, 0, 32'h0,         32'h0,         0);
    vecs[30] = mk(32'h0000_6000, 1, 32'h7777_0007, 0, 0, 1, 32'h0000_6000, 1, 0, 32'h0,         32'h0,         0);
    vecs[31] = mk(32'h0000_6004, 0, 32'h0,        0, 0,  0, 32'h0000_6000, 0, 1, 32'h0000_6000, 32'h7777_0007, 0);

    bus.pc = 32'h0; bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    bus.id_ready = 1'b0; bus.flush = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_req",      -1, 32'(bus.imem_req), 32'h0);
    chk("rst_addr",     -1, bus.imem_addr,     32'h0);
    chk("rst_pc_write", -1, 32'(bus.pc_write), 32'h0);
    chk("rst_valid",    -1, 32'(bus.if_valid), 32'h0);
    chk("rst_if_pc",    -1, bus.if_pc,         32'h0);
    chk("rst_if_instr", -1, bus.if_instr,      32'h0);
    chk("rst_if_exc",   -1, 32'(bus.if_exc),   32'h0);
    reset = 1'b0;

    for (int i = 0; i < c_NVEC; i++) begin
      bus.pc         = vecs[i].pc;
      bus.imem_ack   = vecs[i].ack;
      bus.imem_rdata = vecs[i].rdata;
      bus.id_ready   = vecs[i].idr;
      bus.flush      = vecs[i].flush;
      @(negedge clock);
      chk("imem_req",  i, 32'(bus.imem_req), 32'(vecs[i].req));
      chk("imem_addr", i, bus.imem_addr,     vecs[i].addr);
      chk("pc_write",  i, 32'(bus.pc_write), 32'(vecs[i].pcw));
      chk("if_valid",  i, 32'(bus.if_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        chk("if_pc",    i, bus.if_pc,         vecs[i].hpc);
        chk("if_instr", i, bus.if_instr,      vecs[i].hinstr);
        chk("if_exc",   i, 32'(bus.if_exc),   32'(vecs[i].hexc));
      end
      @(posedge clock);
      #1;
    end

    // Now in REQ for 6004 with the 6000 entry buffered; reset lands mid-cycle.
    bus.pc = 32'h0000_6004; bus.imem_ack = 1'b0; bus.id_ready = 1'b0; bus.flush = 1'b0;
    #2;
    chk("pre_rst_req",   100, 32'(bus.imem_req), 32'h1);
    chk("pre_rst_addr",  100, bus.imem_addr,     32'h0000_6004);
    chk("pre_rst_valid", 100, 32'(bus.if_valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("async_rst_req",    101, 32'(bus.imem_req), 32'h0);
    chk("async_rst_valid",  101, 32'(bus.if_valid), 32'h0);
    chk("async_rst_addr",   101, bus.imem_addr,     32'h0);
    chk("async_rst_if_pc",  101, bus.if_pc,         32'h0);
    chk("async_rst_pcw",    101, 32'(bus.pc_write), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
